// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//   Pipelined immediate generator. Decodes the immediate of a RISC-V
//   instruction, sign/zero-extends it to XLEN, adds it to the PC and flags
//   misaligned branch/jump targets. A result is registered one cycle after
//   it is accepted. A second (skid) register lets the stage take one more
//   instruction while the output is stalled, so the stage keeps full
//   throughput under backpressure.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   flush             synchronous flush, discards every held entry and the
//                     input offered in the same cycle
//   in_valid/in_ready upstream handshake (in_ready is a register output)
//   in_inst           raw 32-bit instruction
//   in_pc             instruction PC (XLEN)
//   in_imm_sel        immediate format select (imm_gen_pkg::IMM_*)
//   out_valid/out_ready downstream handshake
//   out_imm           extended immediate
//   out_target        in_pc + imm, modulo 2^XLEN
//   out_misaligned    target misaligned (IMM_B / IMM_J only)

package imm_gen_pkg;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;
endpackage

module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int HAS_C     = 0,
    parameter int HAS_ZICSR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_misaligned
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            mis;
    } res_t;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] target;
    logic            is_bj;
    res_t            new_res;
    res_t            out_q;
    res_t            skid_q;
    logic            out_vld;
    logic            skid_vld;
    logic            accept;
    logic            unused_opcode;

    // Opcode bits carry no immediate information.
    assign unused_opcode = ^in_inst[6:0];

    // Every format is built as a 32-bit value whose bit 31 is already the
    // correct extension bit (0 for IMM_Z and unknown selects), so widening
    // to XLEN is a plain sign extension for all of them.
    always_comb begin
        imm32 = '0;
        case (in_imm_sel)
            IMM_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            IMM_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            IMM_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            IMM_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            IMM_U: imm32 = {in_inst[31:12], 12'b0};
            IMM_Z: if (HAS_ZICSR != 0) imm32 = {27'b0, in_inst[19:15]};
            default: imm32 = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_ext64
            assign imm_ext = {{32{imm32[31]}}, imm32};
        end else begin : g_ext32
            assign imm_ext = imm32;
        end
    endgenerate

    assign target = in_pc + imm_ext;
    assign is_bj  = (in_imm_sel == IMM_B) || (in_imm_sel == IMM_J);

    always_comb begin
        new_res        = '0;
        new_res.imm    = imm_ext;
        new_res.target = target;
        if (HAS_C != 0) new_res.mis = is_bj & target[0];
        else            new_res.mis = is_bj & (|target[1:0]);
    end

    // in_ready depends only on skid occupancy, so it is a registered signal.
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            // Flush wins over any transfer in the same cycle.
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!out_vld || out_ready) begin
            // Output slot frees up this edge. A full skid means in_ready=0,
            // so no new input can arrive alongside the skid refill.
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= accept;
                if (accept) out_q <= new_res;
            end
        end else if (accept) begin
            // Output stalled: park the new result in the skid entry.
            skid_q   <= new_res;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid      = out_vld;
    assign out_imm        = out_vld ? out_q.imm    : '0;
    assign out_target     = out_vld ? out_q.target : '0;
    assign out_misaligned = out_vld & out_q.mis;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;
    logic [2:0]  in_imm_sel = '0;
    logic [31:0] pc32;

    logic        rdy, vld, mis;
    logic [31:0] imm, tgt;
    logic        rdy_c, vld_c, mis_c;
    logic [31:0] imm_c, tgt_c;
    logic        rdy64, vld64, mis64;
    logic [63:0] imm64, tgt64;

    int tests = 0;
    int fails = 0;

    assign pc32 = in_pc[31:0];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .HAS_C(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy),
        .in_inst(in_inst), .in_pc(pc32), .in_imm_sel(in_imm_sel), .out_valid(vld),
        .out_ready(out_ready), .out_imm(imm), .out_target(tgt), .out_misaligned(mis));

    imm_gen_stage #(.XLEN(32), .HAS_C(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_inst(in_inst), .in_pc(pc32), .in_imm_sel(in_imm_sel), .out_valid(vld_c),
        .out_ready(out_ready), .out_imm(imm_c), .out_target(tgt_c), .out_misaligned(mis_c));

    imm_gen_stage #(.XLEN(64), .HAS_C(0)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_pc(in_pc), .in_imm_sel(in_imm_sel), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_target(tgt64), .out_misaligned(mis64));

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        mis;
        logic        mis_c;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // I-type with rd=rs1=0 carrying a 12-bit immediate
    function automatic logic [31:0] itype(input logic [11:0] v);
        return {v, 20'h00013};
    endfunction

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] i,
                         input logic [63:0] p);
        in_valid   = v;
        in_imm_sel = s;
        in_inst    = i;
        in_pc      = p;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got[$];
        logic [31:0] held;
        int          idx;
        int          last_out;
        int          unstable;
        logic        fire_in, fire_out;
        logic [31:0] cap;

        vt[0]  = '{IMM_I, 32'hFFF00093, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 64'h0FFF, 1'b0, 1'b0};
        vt[1]  = '{IMM_U, 32'h123450B7, 64'h0, 64'h12345000, 64'h12345000, 1'b0, 1'b0};
        vt[2]  = '{IMM_Z, 32'h3400F073, 64'h200, 64'h1, 64'h201, 1'b0, 1'b0};
        vt[3]  = '{IMM_B, 32'hFE000EE3, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'hFC, 1'b0, 1'b0};
        vt[4]  = '{IMM_J, 32'h0020006F, 64'h1000, 64'h2, 64'h1002, 1'b1, 1'b0};
        vt[5]  = '{IMM_J, 32'h0200006F, 64'hFFFFFFFFFFFFFFF0, 64'h20, 64'h10, 1'b0, 1'b0};
        vt[6]  = '{IMM_S, 32'hFE000E23, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
        vt[7]  = '{IMM_U, 32'h800000B7, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
        vt[8]  = '{3'b111, 32'hFFFFFFFF, 64'h44, 64'h0, 64'h44, 1'b0, 1'b0};
        vt[9]  = '{IMM_B, 32'h00000463, 64'h102, 64'h8, 64'h10A, 1'b1, 1'b0};
        vt[10] = '{IMM_B, 32'h00000463, 64'h101, 64'h8, 64'h109, 1'b1, 1'b1};

        // Reset state
        #2;
        chk("rst_out_valid", 64'(vld), 64'h0);
        chk("rst_out_imm", 64'(imm), 64'h0);
        chk("rst_out_target", 64'(tgt), 64'h0);
        chk("rst_out_mis", 64'(mis), 64'h0);
        #10 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(rdy), 64'h1);

        // Back-to-back table vectors, out_ready held high
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vt[i].sel, vt[i].inst, vt[i].pc);
            step();
            chk($sformatf("v%0d_valid", i), 64'(vld), 64'h1);
            chk($sformatf("v%0d_imm32", i), 64'(imm), 64'(vt[i].imm[31:0]));
            chk($sformatf("v%0d_tgt32", i), 64'(tgt), 64'(vt[i].tgt[31:0]));
            chk($sformatf("v%0d_mis", i), 64'(mis), 64'(vt[i].mis));
            chk($sformatf("v%0d_mis_c", i), 64'(mis_c), 64'(vt[i].mis_c));
            chk($sformatf("v%0d_imm64", i), imm64, vt[i].imm);
            chk($sformatf("v%0d_tgt64", i), tgt64, vt[i].tgt);
        end
        drive(1'b0, IMM_I, 32'h0, 64'h0);
        step();
        chk("idle_valid", 64'(vld), 64'h0);
        chk("idle_imm_zero", 64'(imm), 64'h0);

        // Backpressure: 4 instructions, out_ready low for cycles 2..5
        idx = 0;
        last_out = -1;
        unstable = 0;
        held = '0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 5);
            if (idx < 4) drive(1'b1, IMM_I, itype(12'(idx + 1)), 64'h0);
            else         drive(1'b0, IMM_I, 32'h0, 64'h0);
            if (cyc == 0) chk("bp_ready_c0", 64'(rdy), 64'h1);
            if (cyc == 4) chk("bp_ready_c4", 64'(rdy), 64'h0);
            if (vld && !out_ready) begin
                if (cyc > 2 && imm !== held) unstable++;
                held = imm;
            end
            fire_in  = in_valid & rdy;
            fire_out = vld & out_ready;
            cap      = imm;
            step();
            if (fire_in) idx++;
            if (fire_out) begin
                got.push_back(cap);
                last_out = cyc;
            end
        end
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) chk($sformatf("bp_order%0d", k), 64'(got[k]), 64'(k + 1));
        chk("bp_stable", 64'(unstable), 64'd0);
        chk("bp_last_out_cycle", 64'(last_out), 64'd8);

        // Flush with two held entries and an input offered the same cycle
        out_ready = 1'b0;
        drive(1'b1, IMM_I, itype(12'h011), 64'h0);
        step();
        drive(1'b1, IMM_I, itype(12'h022), 64'h0);
        step();
        chk("fl_full_ready", 64'(rdy), 64'h0);
        chk("fl_held_imm", 64'(imm), 64'h11);
        drive(1'b1, IMM_I, itype(12'h033), 64'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, IMM_I, 32'h0, 64'h0);
        chk("fl_valid", 64'(vld), 64'h0);
        chk("fl_ready", 64'(rdy), 64'h1);
        chk("fl_imm_zero", 64'(imm), 64'h0);
        out_ready = 1'b1;
        drive(1'b1, IMM_I, itype(12'h044), 64'h0);
        step();
        drive(1'b0, IMM_I, 32'h0, 64'h0);
        chk("fl_next_valid", 64'(vld), 64'h1);
        chk("fl_next_imm", 64'(imm), 64'h44);
        step();
        chk("fl_next_alone", 64'(vld), 64'h0);

        // Flush while in_ready = 1 also drops the input
        drive(1'b1, IMM_I, itype(12'h077), 64'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, IMM_I, 32'h0, 64'h0);
        chk("fl_rdy_drop", 64'(vld), 64'h0);

        // Asynchronous reset mid-stream
        drive(1'b1, IMM_I, itype(12'h055), 64'h0);
        step();
        chk("ar_pre_valid", 64'(vld), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_async_valid", 64'(vld), 64'h0);
        chk("ar_async_imm", 64'(imm), 64'h0);
        drive(1'b0, IMM_I, 32'h0, 64'h0);
        #3 rst_n = 1'b1;
        step();
        chk("ar_post_valid", 64'(vld), 64'h0);
        chk("ar_post_ready", 64'(rdy), 64'h1);
        drive(1'b1, IMM_I, itype(12'h066), 64'h0);
        step();
        drive(1'b0, IMM_I, 32'h0, 64'h0);
        chk("ar_first_valid", 64'(vld), 64'h1);
        chk("ar_first_imm", 64'(imm), 64'h66);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
